load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  - Initiator side of the data-memory interface. Turns CPU load/store requests
//    (byte/half/word, signed/unsigned) into word-aligned accesses on a word-wide
//    memory with combinational read and clocked full-word write.
//  - Sits between the execute stage and data_memory.
//  - Sub-word stores use a 2-cycle read-modify-write sequence.
// PARAMETERS
//  ADDR_W  `ADDR_LEN  byte-address width
//  DATA_W  `DATA_LEN  data width; only 32 is supported
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       synchronous reset, active-high
//  req_valid     in   1       CPU request valid
//  req_ready     out  1       unit idle, request accepted when valid&&ready
//  req_we        in   1       1=store, 0=load
//  req_size      in   2       00=byte 01=half 10=word 11=reserved (treated as word)
//  req_unsigned  in   1       loads: zero-extend when 1, sign-extend when 0
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   DATA_W  store data, right-aligned (low bits)
//  resp_valid    out  1       one-cycle completion pulse, loads and stores
//  resp_rdata    out  DATA_W  extended load data, valid with resp_valid; 0 for stores
//  resp_misalign out  1       misaligned access, valid with resp_valid
//  mem_addr      out  ADDR_W  word-aligned address {addr[31:2],2'b00}
//  mem_we        out  1       full-word write enable to memory
//  mem_wdata     out  DATA_W  full-word write data
//  mem_rdata     in   DATA_W  combinational read data for mem_addr
// BEHAVIOUR
//  - Reset values: state=IDLE, all request/response registers 0.
//    Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_misalign=0,
//    mem_we=0, mem_addr=0, mem_wdata=0.
//  - FSM states: IDLE, ACCESS, WRITE, RESP.
//    - IDLE: req_ready=1. On valid&&ready, latch we/size/unsigned/addr/wdata,
//      then go to ACCESS. Without a request, stay in IDLE.
//    - ACCESS: mem_addr is driven from the latched address.
//      - Load: extract lane from mem_rdata, register it into resp_rdata, go to RESP.
//      - Word store: mem_we=1, mem_wdata=wdata, go to RESP.
//      - Sub-word store: register mem_rdata into merge_q, go to WRITE.
//    - WRITE: mem_we=1. mem_wdata = merge_q with the target lane replaced by
//      the low byte/half of wdata. Go to RESP.
//    - RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
//      There is no backpressure.
//  - req_ready=0 in every state except IDLE.
//  - Latency, counted as cycles from the accept edge to the resp_valid cycle:
//    load=2, word store=2, sub-word store=3.
//  - Lane selection is little-endian:
//    - byte lane = addr[1:0]
//    - half lane = addr[1] (0 selects [15:0], 1 selects [31:16])
//  - Sign extension uses bit 7 (byte) or bit 15 (half) of the selected lane.
//  - mem_we is forced to 0 whenever rst=1. Reset in ACCESS/WRITE aborts the
//    access: no partial write, no resp_valid.
//  - Memory is never written outside ACCESS (word store) or WRITE.
// CONFIGURATION
//  - Macro LSU_MISALIGN_CHECK_EN.
//  - Defined:
//    - half with addr[0]!=0, or word with addr[1:0]!=0, goes IDLE->RESP directly.
//    - No mem_we, resp_misalign=1, resp_rdata=0.
//  - Undefined:
//    - Offending low address bits are ignored (half uses addr[1] only, word
//      uses neither).
//    - resp_misalign is tied 0.
// STRUCTURE
//  - defines.v gains:
//    - size codes `SIZE_B / `SIZE_H / `SIZE_W
//    - state codes `LSU_IDLE / `LSU_ACCESS / `LSU_WRITE / `LSU_RESP (2-bit)
//  - Sub-module lsu_align (combinational):
//    - load extract + extend: (word, addr[1:0], size, unsigned) -> data
//    - store merge: (word, wdata, addr[1:0], size) -> word
//  - The top level holds the FSM and registers only.
// TESTING (bench uses a behavioural model of data_memory)
//  1. sw 0x8899AABB @0x10 -> one mem_we pulse, word[0x10]=0x8899AABB, resp_valid 2 cycles after accept.
//  2. sb 0x000000CC @0x11 -> one ACCESS read, then a single write; word[0x10]=0x8899CCBB.
//  3. lb @0x13 -> 0xFFFFFF88; lbu @0x13 -> 0x00000088; lh @0x12 -> 0xFFFF8899; lhu @0x10 -> 0x0000CCBB.
//  4. lw @0x13, macro on -> resp_misalign=1, rdata=0, no mem_we.
//     Macro off -> rdata=0x8899CCBB, resp_misalign=0.
//  5. sh 0x1234 @0x12, rst=1 in the WRITE cycle -> mem_we stays 0, word[0x10] unchanged,
//     no resp_valid, req_ready=1 next cycle.
//  6. Back-to-back: req_valid held high with 3 loads -> each accepted only in IDLE,
//     3 resp_valid pulses, 3 cycles apart.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM state encoding and helpers for the load/store unit.
// Optional misalignment trapping is enabled with LSU_MISALIGN_CHECK_EN.
package load_store_unit_pkg;

    localparam int LSU_ADDR_LEN = 32;
    localparam int LSU_DATA_LEN = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_WRITE  = 2'b10,
        LSU_RESP   = 2'b11
    } lsu_state_t;

    // The reserved size code 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_H) && offset[0]) || (is_word(size) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [15:0] wdata_lo,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half accesses look only at offset[1]; word accesses ignore the offset.
    always_comb begin
        byte_lane  = mem_word[{offset, 3'b000} +: 8];
        half_lane  = offset[1] ? mem_word[31:16] : mem_word[15:0];
        load_data  = mem_word;
        store_word = mem_word;
        if (size == SIZE_B) begin
            load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            store_word[{offset, 3'b000} +: 8] = wdata_lo[7:0];
        end else if (size == SIZE_H) begin
            load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            store_word[{offset[1], 4'b0000} +: 16] = wdata_lo;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: FSM and request registers driving a word-wide data memory.
// Define LSU_MISALIGN_CHECK_EN to complete misaligned half/word accesses with resp_misalign.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_LEN,
    parameter int DATA_W = LSU_DATA_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;
    logic              misalign_q;
    logic              accept;
    logic              mis_now;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis_now = is_misaligned(req_size, req_addr[1:0]);
`else
    assign mis_now = 1'b0;
`endif

    assign accept        = req_valid && (state_q == LSU_IDLE);
    assign req_ready     = (state_q == LSU_IDLE);
    assign resp_valid    = (state_q == LSU_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_misalign = misalign_q;
    assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};

    // Loads read the live memory word; the merge in WRITE uses the snapshot.
    load_store_unit_align u_align (
        .mem_word    ((state_q == LSU_WRITE) ? merge_q : mem_rdata),
        .wdata_lo    (wdata_q[15:0]),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
                misalign_q <= mis_now;
            end
            if (state_q == LSU_ACCESS) begin
                if (!we_q) begin
                    rdata_q <= load_data;
                end else if (!is_word(size_q)) begin
                    merge_q <= mem_rdata;
                end
            end
        end
    end

    // Reset overrides the write strobe so an interrupted access never lands.
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    state_d = mis_now ? LSU_RESP : LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                if (we_q && !is_word(size_q)) begin
                    state_d = LSU_WRITE;
                end else begin
                    state_d = LSU_RESP;
                    if (we_q) begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata_q;
                    end
                end
            end
            LSU_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = store_word;
                state_d   = LSU_RESP;
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-level reference memory model.
// Expectations follow LSU_MISALIGN_CHECK_EN when the bench is built with it.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        misalign;
        int          latency;
        int          we_total;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] init_mem [16];
    logic [31:0] mem      [16];
    logic [31:0] ref_mem  [16];
    logic        load_init;

    exp_t exp_q[$];
    int   acc_q[$];
    int   nChecks;
    int   nFails;
    int   cyc;
    int   we_count;
    int   ref_we_total;
    int   gap_on;
    int   gap_prev;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 16 words, combinational read, clocked full-word write.
    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[5:2]];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model computes the response from byte-lane arithmetic, then the request is driven.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [5:0] addr, input logic [31:0] wdata, input logic hold);
        exp_t        e;
        logic [1:0]  sz;
        int          idx;
        int          sh;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        logic        mis;
        int          n;
        sz  = (size == 2'b11) ? 2'b10 : size;
        idx = int'(addr[5:2]);
        w   = ref_mem[idx];
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ((sz == 2'b01) && addr[0]) || ((sz == 2'b10) && (addr[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        e.misalign = mis;
        e.rdata    = 32'h0;
        if (mis) begin
            e.latency = 1;
        end else if (!we) begin
            e.latency = 2;
            if (sz == 2'b00) begin
                sh = 8 * int'(addr[1:0]);
                v  = (w >> sh) & 32'h0000_00FF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                sh = 16 * int'(addr[1]);
                v  = (w >> sh) & 32'h0000_FFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            e.rdata = v;
        end else begin
            ref_we_total++;
            if (sz == 2'b10) begin
                e.latency    = 2;
                ref_mem[idx] = wdata;
            end else begin
                e.latency    = 3;
                sh           = (sz == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
                mask         = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
                ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
            end
        end
        e.we_total = ref_we_total;
        exp_q.push_back(e);

        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = {26'h0, addr};
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: req_ready stayed 0, required 1");
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL resp_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        nChecks      = 0;
        nFails       = 0;
        cyc          = 0;
        we_count     = 0;
        ref_we_total = 0;
        gap_on       = 0;
        gap_prev     = -1;
        rst          = 1'b1;
        load_init    = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        for (int i = 0; i < 16; i++) begin
            init_mem[i] = $urandom;
            ref_mem[i]  = init_mem[i];
        end

        // Monitor: samples 1 time unit after each falling edge and pops the scoreboard on resp_valid.
        fork
            forever begin
                exp_t e;
                int   a;
                @(negedge clk);
                #1;
                cyc++;
                if (mem_we) we_count++;
                if (rst) begin
                    acc_q.delete();
                end else begin
                    if (req_valid && req_ready) acc_q.push_back(cyc);
                    if (resp_valid) begin
                        if (gap_on != 0) begin
                            if (gap_prev >= 0) checkOutput("resp_gap", cyc - gap_prev, 3);
                            gap_prev = cyc;
                        end
                        if (exp_q.size() == 0) begin
                            nChecks++;
                            nFails++;
                            $display("[TB] FAIL unexpected_resp: resp_valid=1, required 0");
                        end else begin
                            e = exp_q.pop_front();
                            a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                            checkOutput("resp_rdata", resp_rdata, e.rdata);
                            checkOutput("resp_misalign", {31'h0, resp_misalign}, {31'h0, e.misalign});
                            checkOutput("latency", cyc - a, e.latency);
                            checkOutput("mem_we_count", we_count, e.we_total);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_resp_misalign", {31'h0, resp_misalign}, 32'h0);
        checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        rst       = 1'b0;
        load_init = 1'b0;
        @(negedge clk);

        // Directed: sw, sb merge, then signed/unsigned byte and half loads of the merged word.
        applyStimulus(1'b1, 2'b10, 1'b0, 6'h10, 32'h8899AABB, 1'b0); waitDone();
        applyStimulus(1'b1, 2'b00, 1'b0, 6'h11, 32'h000000CC, 1'b0); waitDone();
        applyStimulus(1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 1'b0); waitDone();
        applyStimulus(1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 1'b0); waitDone();
        applyStimulus(1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 1'b0); waitDone();
        applyStimulus(1'b0, 2'b01, 1'b1, 6'h10, 32'h0, 1'b0); waitDone();
        applyStimulus(1'b0, 2'b10, 1'b0, 6'h13, 32'h0, 1'b0); waitDone();
        checkOutput("word_0x10", mem[4], ref_mem[4]);

        // Reset during WRITE of a half store must drop the write and the response.
        req_we       = 1'b1;
        req_size     = 2'b01;
        req_unsigned = 1'b0;
        req_addr     = 32'h12;
        req_wdata    = 32'h1234;
        req_valid    = 1'b1;
        checkOutput("abort_ready_before", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready_after", {31'h0, req_ready}, 32'h1);
        checkOutput("abort_word_0x10", mem[4], ref_mem[4]);
        repeat (4) @(negedge clk);

        // Back-to-back loads with req_valid held high: responses three cycles apart.
        gap_on   = 1;
        gap_prev = -1;
        applyStimulus(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b1, 6'h11, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 1'b0);
        waitDone();
        gap_on = 0;

        repeat (80) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        waitDone();

        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
